// File: rtl/outbuf_credit_pkg.sv
// Shared encodings and default widths for the outbuf_credit output stage.
// Optional statistics counters are enabled with OUTBUF_STATS_EN.
package outbuf_credit_pkg;

    localparam int unsigned DATAW_DEF   = 66;
    localparam int unsigned VCH_DEF     = 2;
    localparam int unsigned VCHW_DEF    = $clog2(VCH_DEF);
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned CREDITS_DEF = 4;

    // Flit type lives in the top TYPE_W bits of the flit.
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] TYPE_NONE = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_HEAD = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_DATA = 2'b10;
    localparam logic [TYPE_W-1:0] TYPE_TAIL = 2'b11;

endpackage

// File: rtl/outbuf_fifo.sv
// Generic synchronous FIFO; head entry is visible combinationally on rdata_c.
module outbuf_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTRW = $clog2(DEPTH),
    localparam int unsigned CNTW = PTRW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rdata_c = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + CNTW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CNTW'(1);
        end
    end

    // Flags are registered from the next count, so a same-cycle read never clears full early.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTRW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTRW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNTW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/outbuf_credit.sv
// Router output stage: buffers mux flits and sends them on the link under per-VC credits.
// Define OUTBUF_STATS_EN to add the stat_flits / stat_pkts counters.
module outbuf_credit
    import outbuf_credit_pkg::*;
#(
    parameter int unsigned DATAW   = DATAW_DEF,
    parameter int unsigned VCH     = VCH_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CREDITS = CREDITS_DEF,
    localparam int unsigned VCHW   = $clog2(VCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    output logic             full,
    output logic [DATAW-1:0] odata,
    output logic             ovalid,
    output logic [VCHW-1:0]  ovch,
    input  logic             icredit,
    input  logic [VCHW-1:0]  icredit_vch,
`ifdef OUTBUF_STATS_EN
    output logic             err_credit,
    output logic [31:0]      stat_flits,
    output logic [31:0]      stat_pkts
`else
    output logic             err_credit
`endif
);

    localparam int unsigned EW   = DATAW + VCHW;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned CW   = $clog2(CREDITS + 1);

    logic [EW-1:0]    head;
    logic [DATAW-1:0] head_data;
    logic [VCHW-1:0]  head_vch;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNTW-1:0]  fifo_count;
    logic             unused_count;
    logic             send_c;
    logic [CW-1:0]    credit     [VCH];
    logic [CW-1:0]    credit_nxt [VCH];
    logic             err_nxt;

    outbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (ivalid),
        .wdata   ({ivch, idata}),
        .rd      (send_c),
        .rdata_c (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign full         = fifo_full;
    assign unused_count = ^fifo_count;
    assign head_data    = head[DATAW-1:0];
    assign head_vch     = head[EW-1 -: VCHW];

    // Eligibility uses the registered counter: a returned credit only helps from the next cycle.
    assign send_c = !fifo_empty && (credit[head_vch] != '0);

    always_comb begin
        err_nxt = err_credit;
        for (int v = 0; v < VCH; v++) begin
            credit_nxt[v] = credit[v];
            if (icredit && (icredit_vch == VCHW'(v))) begin
                if (credit[v] == CW'(CREDITS)) begin
                    err_nxt = 1'b1;
                end else if (!(send_c && (head_vch == VCHW'(v)))) begin
                    credit_nxt[v] = credit[v] + CW'(1);
                end
            end else if (send_c && (head_vch == VCHW'(v))) begin
                credit_nxt[v] = credit[v] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VCH; v++) credit[v] <= CW'(CREDITS);
            err_credit <= 1'b0;
            ovalid     <= 1'b0;
            odata      <= '0;
            ovch       <= '0;
        end else begin
            for (int v = 0; v < VCH; v++) credit[v] <= credit_nxt[v];
            err_credit <= err_nxt;
            ovalid     <= send_c;
            if (send_c) begin
                odata <= head_data;
                ovch  <= head_vch;
            end
        end
    end

`ifdef OUTBUF_STATS_EN
    // Link statistics; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flits <= '0;
            stat_pkts  <= '0;
        end else if (send_c) begin
            stat_flits <= stat_flits + 32'(1);
            if (head_data[DATAW-1 -: TYPE_W] == TYPE_TAIL) stat_pkts <= stat_pkts + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_outbuf_credit.sv
// Directed self-checking bench for outbuf_credit (OUTBUF_STATS_EN adds statistics checks).
module tb_outbuf_credit;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic        clk;
    logic        rst;
    logic [65:0] idata;
    logic        ivalid;
    logic [0:0]  ivch;
    logic        full;
    logic [65:0] odata;
    logic        ovalid;
    logic [0:0]  ovch;
    logic        icredit;
    logic [0:0]  icredit_vch;
    logic        err_credit;
`ifdef OUTBUF_STATS_EN
    logic [31:0] stat_flits;
    logic [31:0] stat_pkts;
`endif

    int errors = 0;
    int checks = 0;
    int proto_flags = 0;
    int seen;

    logic [65:0] pk [22];
    logic [65:0] q  [6];
    logic [65:0] g  [4];
    logic [65:0] k  [3];

    outbuf_credit dut (
        .clk         (clk),
        .rst         (rst),
        .idata       (idata),
        .ivalid      (ivalid),
        .ivch        (ivch),
        .full        (full),
        .odata       (odata),
        .ovalid      (ovalid),
        .ovch        (ovch),
        .icredit     (icredit),
        .icredit_vch (icredit_vch),
`ifdef OUTBUF_STATS_EN
        .err_credit  (err_credit),
        .stat_flits  (stat_flits),
        .stat_pkts   (stat_pkts)
`else
        .err_credit  (err_credit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] mkf(input logic [1:0] t, input int n);
        return {t, 32'hA5A50000, 32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ivalid      = 1'b0;
        idata       = '0;
        ivch        = '0;
        icredit     = 1'b0;
        icredit_vch = '0;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_full", full, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_err", err_credit, 0);
        chk("rst_odata", odata, 0);
        chk("rst_ovch", ovch, 0);
        chk("rst_credit0", dut.credit[0], 4);
        chk("rst_credit1", dut.credit[1], 4);
        chk("rst_count", dut.u_fifo.count, 0);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (ovalid) seen++;
        end
        chk("idle_ovalid", seen, 0);

        // 22-flit packet on vch 1, credits returned every cycle after the first send
        for (int i = 0; i < 22; i++)
            pk[i] = mkf((i == 0) ? T_HEAD : (i == 21) ? T_TAIL : T_DATA, i);
        for (int c = 0; c < 24; c++) begin
            ivalid = (c < 22);
            if (c < 22) idata = pk[c];
            else idata = '0;
            ivch        = 1'b1;
            icredit     = (c >= 2);
            icredit_vch = 1'b1;
            tick();
            if (c == 0 || c == 23) chk($sformatf("pkt_gap_c%0d", c), ovalid, 0);
            else chk($sformatf("pkt_f%0d", c - 1), {ovalid, ovch, odata}, {1'b1, 1'b1, pk[c - 1]});
        end
        idle();
        chk("pkt_credit1", dut.credit[1], 4);
        chk("pkt_err", err_credit, 0);
`ifdef OUTBUF_STATS_EN
        chk("pkt_stat_flits", stat_flits, 22);
        chk("pkt_stat_pkts", stat_pkts, 1);
`endif

        // Six flits on vch 0 with no credit return: only four leave
        for (int i = 0; i < 6; i++) q[i] = mkf(T_DATA, 100 + i);
        for (int c = 0; c < 6; c++) begin
            ivalid = 1'b1;
            idata  = q[c];
            ivch   = 1'b0;
            tick();
            if (c == 0 || c == 5) chk($sformatf("starve_gap_c%0d", c), ovalid, 0);
            else chk($sformatf("starve_f%0d", c - 1), {ovalid, ovch, odata}, {1'b1, 1'b0, q[c - 1]});
        end
        idle();
        tick();
        chk("starve_hold", {ovalid, odata}, {1'b0, q[3]});
        chk("starve_count", dut.u_fifo.count, 2);
        chk("starve_full", full, 0);
        chk("starve_credit0", dut.credit[0], 0);
        icredit     = 1'b1;
        icredit_vch = 1'b0;
        tick();
        chk("credit_not_same_cycle", ovalid, 0);
        icredit = 1'b0;
        tick();
        chk("credit_f4", {ovalid, ovch, odata}, {1'b1, 1'b0, q[4]});
        tick();
        chk("credit_f5_blocked", ovalid, 0);

        // Continuous input while starved fills the FIFO; the fourth flit meets full and is dropped
        for (int i = 0; i < 4; i++) g[i] = mkf(T_DATA, 200 + i);
        for (int c = 0; c < 4; c++) begin
            ivalid = 1'b1;
            idata  = g[c];
            ivch   = 1'b0;
            if (ivalid && full) proto_flags++;
            tick();
            chk($sformatf("fill_full_c%0d", c), full, (c >= 2));
        end
        idle();
        chk("fill_proto_flags", proto_flags, 1);
        chk("fill_count", dut.u_fifo.count, 4);

        // Drain with credits, including credit return and send on the same VC
        icredit     = 1'b1;
        icredit_vch = 1'b0;
        tick();
        chk("drain_e1_ovalid", ovalid, 0);
        chk("drain_e1_full", full, 1);
        tick();
        chk("drain_f5", {ovalid, ovch, odata}, {1'b1, 1'b0, q[5]});
        chk("drain_full_clear", full, 0);
        tick();
        chk("drain_g0", {ovalid, ovch, odata}, {1'b1, 1'b0, g[0]});
        chk("credit_same_cycle", dut.credit[0], 1);
        tick();
        chk("drain_g1", {ovalid, ovch, odata}, {1'b1, 1'b0, g[1]});
        icredit = 1'b0;
        tick();
        chk("drain_g2", {ovalid, ovch, odata}, {1'b1, 1'b0, g[2]});
        tick();
        chk("drain_dropped", ovalid, 0);
        chk("drain_count", dut.u_fifo.count, 0);
        chk("drain_credit0", dut.credit[0], 0);

        // Credit overflow on vch 1 sets a sticky error
        icredit     = 1'b1;
        icredit_vch = 1'b1;
        tick();
        icredit = 1'b0;
        chk("ovf_err", err_credit, 1);
        chk("ovf_credit1", dut.credit[1], 4);
        repeat (3) tick();
        chk("ovf_sticky", err_credit, 1);

        // Reset with three flits buffered, then a fresh packet
        for (int c = 0; c < 3; c++) begin
            ivalid = 1'b1;
            idata  = mkf(T_DATA, 300 + c);
            ivch   = 1'b0;
            tick();
        end
        idle();
        chk("mid_count", dut.u_fifo.count, 3);
        chk("mid_ovalid", ovalid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_count", dut.u_fifo.count, 0);
        chk("rst2_ovalid", ovalid, 0);
        chk("rst2_credit0", dut.credit[0], 4);
        chk("rst2_credit1", dut.credit[1], 4);
        chk("rst2_err", err_credit, 0);
        chk("rst2_full", full, 0);
        chk("rst2_odata", odata, 0);
        k[0] = mkf(T_HEAD, 400);
        k[1] = mkf(T_DATA, 401);
        k[2] = mkf(T_TAIL, 402);
        for (int c = 0; c < 4; c++) begin
            ivalid = (c < 3);
            if (c < 3) idata = k[c];
            else idata = '0;
            ivch = 1'b1;
            tick();
            if (c == 0) chk("new_lat", ovalid, 0);
            else chk($sformatf("new_f%0d", c - 1), {ovalid, ovch, odata}, {1'b1, 1'b1, k[c - 1]});
        end
        idle();
        chk("new_credit1", dut.credit[1], 1);
`ifdef OUTBUF_STATS_EN
        chk("new_stat_flits", stat_flits, 3);
        chk("new_stat_pkts", stat_pkts, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
